// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard controller for the in-order 5-stage RISC-V pipeline. It drives the
// stall and synchronous-clear inputs of the D/E/M/W pipeline registers and
// the operand-forwarding selects of the execute stage. It sequences load-use
// bubbles, branch/jump squashes, multi-cycle execute operations (mul/div,
// with a timeout abort) and data-memory wait states.
//
// Parameters
//   MC_TIMEOUT : max cycles a multi-cycle op may occupy E (>= 2)
//
// Ports
//   clk, rst_n                  : clock, asynchronous active-low reset
//   ad1d, ad2d                  : decode-stage source registers
//   ad1e, ad2e, rde             : execute-stage sources / destination
//   regWrte, resltSrce          : execute-stage writeback controls (01 = load)
//   pcSrce                      : branch taken / jump resolved in E
//   mcStarte, mcDone            : multi-cycle op in E / result valid
//   rdm, regWrtm, memReqm       : memory-stage destination, write, request
//   dmemRdy                     : data memory ready
//   rdw, regWrtw                : writeback-stage destination and write
//   stallF/D/E/M                : hold PC and D/E/M pipeline registers
//   flushD/E/M/W                : synchronous clear of D/E/M/W registers
//   fwdAe, fwdBe                : forward select (00 RF, 01 W, 10 M)
//   mcErr                       : sticky multi-cycle timeout flag
//   stallCnt                    : stall-cycle counter
//
// Optional feature
//   HAZARD_PERF_CNT_EN : when defined, stallCnt counts cycles with stallF=1;
//                        otherwise stallCnt is tied to 0 and no flops exist.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MC_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ad1d,
    input  logic [4:0]  ad2d,
    input  logic [4:0]  ad1e,
    input  logic [4:0]  ad2e,
    input  logic [4:0]  rde,
    input  logic        regWrte,
    input  logic [1:0]  resltSrce,
    input  logic        pcSrce,
    input  logic        mcStarte,
    input  logic        mcDone,
    input  logic [4:0]  rdm,
    input  logic        regWrtm,
    input  logic        memReqm,
    input  logic        dmemRdy,
    input  logic [4:0]  rdw,
    input  logic        regWrtw,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        flushD,
    output logic        flushE,
    output logic        flushM,
    output logic        flushW,
    output logic [1:0]  fwdAe,
    output logic [1:0]  fwdBe,
    output logic        mcErr,
    output logic [31:0] stallCnt
);

    localparam int CW = $clog2(MC_TIMEOUT);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MCWAIT = 2'd1,
        ABORT  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mc_err_q, mc_err_d;
    logic            load_use;
    logic            mem_wait;

    // Memory stage has priority over writeback: it holds the younger result.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] rd_m, input logic wr_m,
                                           input logic [4:0] rd_w, input logic wr_w);
        if (wr_m && rd_m != 5'd0 && rd_m == src)      return 2'b10;
        else if (wr_w && rd_w != 5'd0 && rd_w == src) return 2'b01;
        else                                          return 2'b00;
    endfunction

    assign fwdAe = fwd_sel(ad1e, rdm, regWrtm, rdw, regWrtw);
    assign fwdBe = fwd_sel(ad2e, rdm, regWrtm, rdw, regWrtw);

    // regWrte is implied by a load; only the result source marks the hazard.
    assign load_use = (resltSrce == 2'b01) && (rde != 5'd0) &&
                      ((rde == ad1d) || (rde == ad2d));
    assign mem_wait = memReqm && !dmemRdy;

    always_comb begin
        // NOTE: every output and next-state gets a default first so that no
        // path through the branches below can leave a latch behind.
        stallF   = 1'b0;
        stallD   = 1'b0;
        stallE   = 1'b0;
        stallM   = 1'b0;
        flushD   = 1'b0;
        flushE   = 1'b0;
        flushM   = 1'b0;
        flushW   = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        mc_err_d = mc_err_q;

        if (!rst_n) begin
            // Load bubbles into every pipeline register while in reset.
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
            flushW = 1'b1;
        end else if (mem_wait) begin
            // Freeze the whole pipe; state and timeout counter hold.
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (pcSrce) begin
                        flushD = 1'b1;
                        flushE = 1'b1;
                    end else if (load_use) begin
                        stallF = 1'b1;
                        stallD = 1'b1;
                        flushE = 1'b1;
                    end else if (mcStarte && !mcDone) begin
                        stallF  = 1'b1;
                        stallD  = 1'b1;
                        stallE  = 1'b1;
                        flushM  = 1'b1;
                        cnt_d   = '0;
                        state_d = MCWAIT;
                    end
                end
                MCWAIT: begin
                    if (mcDone) begin
                        state_d = RUN;
                    end else if (cnt_q == CW'(MC_TIMEOUT - 1)) begin
                        // Release E so ABORT can clear the hung op next cycle.
                        stallF   = 1'b1;
                        stallD   = 1'b1;
                        flushM   = 1'b1;
                        mc_err_d = 1'b1;
                        state_d  = ABORT;
                    end else begin
                        stallF = 1'b1;
                        stallD = 1'b1;
                        stallE = 1'b1;
                        flushM = 1'b1;
                        cnt_d  = cnt_q + CW'(1);
                    end
                end
                ABORT: begin
                    flushE  = 1'b1;
                    state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // NOTE: the asynchronous reset returns the FSM to RUN the moment rst_n
    // falls; state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            mc_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mc_err_q <= mc_err_d;
        end
    end

    assign mcErr = mc_err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      stall_cnt_q <= '0;
        else if (stallF) stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stallCnt = stall_cnt_q;
`else
    assign stallCnt = 32'd0;
`endif

endmodule
